// File: rtl/uart_fifo_param_if.sv
// Bus-side bundle for uart_fifo_param: write/read handshake, flush and status.
// The master drives requests; the slave (the FIFO) drives data and status.
interface uart_fifo_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              flush;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underflow;
    logic [ADDR_W:0]   peak_level;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  rd_data, empty, full, almost_empty, almost_full, level,
               overflow, underflow, peak_level
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output rd_data, empty, full, almost_empty, almost_full, level,
               overflow, underflow, peak_level
    );
endinterface

// File: rtl/uart_fifo_param.sv
// First-word-fall-through FIFO for the UART Tx/Rx paths with level, watermarks and sticky errors.
// Optional high-water mark enabled by defining UART_FIFO_PEAK_EN.
module uart_fifo_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned AF_THRESH = 12,
    parameter int unsigned AE_THRESH = 2
) (
    input logic               CLK,
    input logic               RST_N,
    uart_fifo_param_if.slave  bus
);
    localparam int unsigned      DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  AF_T    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0]  AE_T    = (ADDR_W + 1)'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              full, empty;
    logic              wr_ok, rd_ok;

    assign empty = (level_q == '0);
    assign full  = (level_q == DEPTH_L);

    // Flush suppresses both requests so nothing is stored or popped that cycle.
    assign wr_ok = bus.wr_en & ~full & ~bus.flush;
    assign rd_ok = bus.rd_en & ~empty & ~bus.flush;

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (bus.flush) begin
            w_ptr_d     = '0;
            r_ptr_d     = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_ok) w_ptr_d = w_ptr_q + ADDR_W'(1);
            if (rd_ok) r_ptr_d = r_ptr_q + ADDR_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
                2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
                default: level_d = level_q;
            endcase
            if (bus.wr_en && full)  overflow_d  = 1'b1;
            if (bus.rd_en && empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (wr_ok) mem[w_ptr_q] <= bus.wr_data;
    end

    assign bus.rd_data      = mem[r_ptr_q];
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = (level_q <= AE_T);
    assign bus.almost_full  = (level_q >= AF_T);
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

`ifdef UART_FIFO_PEAK_EN
    logic [ADDR_W:0] peak_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            peak_q <= '0;
        end else if (bus.flush) begin
            peak_q <= '0;
        end else if (level_d > peak_q) begin
            peak_q <= level_d;
        end
    end

    assign bus.peak_level = peak_q;
`else
    assign bus.peak_level = '0;
`endif

endmodule
